tmr_arb: RTL and testbench

TMR_ARB -- requirements
Module: tmr_arb

---
 rtl/tmr_arb_pkg.sv | 22 ++
 rtl/tmr_arb_sel.sv | 63 ++++++
 rtl/tmr_arb.sv | 116 +++++++++++
 tb/tb_tmr_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_arb_pkg.sv
// tmr_arb_pkg: shared definitions for the timer arbiter.
//   - state_t   : controller states (IDLE, RUN, GAP)
//   - NREQ_DEF  : default number of requesters
//   - CW_DEF    : default counter / interval width
//   - idx_w()   : width of a requester index for a given NREQ
package tmr_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CW_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // At least one bit even for degenerate requester counts.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tmr_arb_sel.sv
// tmr_arb_sel: combinational winner selection for tmr_arb.
// Policy macro: TMR_ARB_RR_EN
//   defined   -> round-robin, search starts at rr_ptr+1 (mod NREQ)
//   undefined -> fixed priority, lowest set index wins (rr_ptr ignored)
// Ports:
//   req     in  [NREQ-1:0]  request vector
//   rr_ptr  in  [IW-1:0]    index of the previous winner
//   win     out [NREQ-1:0]  one-hot winner (0 when no request)
//   win_idx out [IW-1:0]    index of the winner (0 when no request)
module tmr_arb_sel
    import tmr_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    logic          found;
    logic [IW-1:0] cand;

`ifdef TMR_ARB_RR_EN
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // Offsets 1..NREQ visit every index once, ending at rr_ptr itself.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found      = 1'b1;
                win        = '0;
                win[cand]  = 1'b1;
                win_idx    = cand;
            end
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'(i);
            if (!found && req[cand]) begin
                found      = 1'b1;
                win        = '0;
                win[cand]  = 1'b1;
                win_idx    = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/tmr_arb.sv
// tmr_arb: arbitrated shared interval timer.
// A winner among the requesters is granted the shared counter, which counts
// 0..len_q (len latched at grant). Completion pulses done to the winner for
// one cycle; dropping the request aborts without done. A one-cycle GAP
// separates consecutive grants.
// Policy macro: TMR_ARB_RR_EN (round-robin when defined, fixed priority
// otherwise; rr_ptr only exists in the round-robin build).
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   req   in   [NREQ-1:0]     per-requester request level
//   len   in   [NREQ*CW-1:0]  per-requester interval, slice i = len[i*CW +: CW]
//   hold  in   freezes the running count
//   gnt   out  [NREQ-1:0]     one-hot grant during the timed interval
//   done  out  [NREQ-1:0]     one-cycle completion pulse
//   busy  out  high while in RUN
//   cnt   out  [CW-1:0]       shared counter value
module tmr_arb
    import tmr_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    input  logic             hold,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [CW-1:0]    cnt
);

    localparam int unsigned IW = idx_w(NREQ);

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [NREQ-1:0] sel_win;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   rr_ptr;

`ifdef TMR_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= IW'(NREQ - 1);
        else if (state == IDLE && |req)
            rr_ptr <= sel_idx;
    end
`else
    assign rr_ptr = IW'(NREQ - 1);
`endif

    tmr_arb_sel #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_sel (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (sel_win),
        .win_idx (sel_idx)
    );

    // gnt is onehot(w) throughout RUN, so req & gnt tests req[w] without
    // keeping a separate winner-index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (|req) begin
                        gnt   <= sel_win;
                        cnt   <= '0;
                        len_q <= len[int'(sel_idx) * CW +: CW];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (~|(req & gnt)) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= GAP;
                    end else if (!hold) begin
                        if (cnt == len_q) begin
                            done  <= gnt;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= GAP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                GAP: begin
                    done  <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_arb.sv
module tb_tmr_arb;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*CW-1:0] len = '0;
    logic            hold = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [CW-1:0]   cnt;

    int checks   = 0;
    int failures = 0;

    tmr_arb #(.NREQ(NREQ), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .hold (hold),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    // Reference model: which requester owns the timer, how many unheld
    // cycles it has counted, and whether we are between grants.
    int m_owner;      // -1 when nobody owns the timer
    int m_elapsed;
    int m_limit;
    int m_last;
    int m_gap_left;   // cycles of GAP still to spend before arbitration
    int m_done_to;    // requester receiving the done pulse, -1 none
    int m_cnt_shown;

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef TMR_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_elapsed = 0; m_limit = 0; m_last = NREQ - 1;
        m_gap_left = 0; m_done_to = -1; m_cnt_shown = 0;
    endtask

    task automatic model_step();
        int w;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1; m_gap_left = 1; m_done_to = -1;
            end else if (!hold) begin
                if (m_elapsed == m_limit) begin
                    m_done_to = m_owner; m_owner = -1; m_gap_left = 1;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left = 0; m_done_to = -1;
        end else begin
            m_done_to = -1;
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_elapsed = 0;
                m_limit = int'(len[w*CW +: CW]);
            end
        end
        m_cnt_shown = m_elapsed;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [NREQ-1:0]    r;
        logic [NREQ*CW-1:0] l;
        logic               h;
        logic [NREQ-1:0]    g;
        logic [NREQ-1:0]    d;
        logic               b;
        logic [CW-1:0]      c;
    } vec_t;

    vec_t vt[25];

    int gidx[$];
    int gcyc[$];
    logic [NREQ-1:0] prev_g;
    logic [NREQ-1:0] rr_exp [5];
    bit seen;

    initial begin
        // Single grant, len change ignored mid-run
        vt[0]  = '{4'b0010, 32'h0000_0300, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd0};
        vt[1]  = '{4'b0010, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd1};
        vt[2]  = '{4'b0010, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd2};
        vt[3]  = '{4'b0010, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd3};
        vt[4]  = '{4'b0010, 32'h0000_0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'd3};
        vt[5]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd3};
        vt[6]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd3};
        // Hold for 3 cycles at cnt=2, len2=5
        vt[7]  = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd0};
        vt[8]  = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd1};
        vt[9]  = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd2};
        vt[10] = '{4'b0100, 32'h0005_0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 8'd2};
        vt[11] = '{4'b0100, 32'h0005_0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 8'd2};
        vt[12] = '{4'b0100, 32'h0005_0000, 1'b1, 4'b0100, 4'b0000, 1'b1, 8'd2};
        vt[13] = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd3};
        vt[14] = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd4};
        vt[15] = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 8'd5};
        vt[16] = '{4'b0100, 32'h0005_0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'd5};
        vt[17] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd5};
        // Abort of requester 3 at cnt=4, len3=10
        vt[18] = '{4'b1000, 32'h0A00_0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'd0};
        vt[19] = '{4'b1000, 32'h0A00_0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'd1};
        vt[20] = '{4'b1000, 32'h0A00_0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'd2};
        vt[21] = '{4'b1000, 32'h0A00_0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'd3};
        vt[22] = '{4'b1000, 32'h0A00_0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 8'd4};
        vt[23] = '{4'b0000, 32'h0A00_0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd4};
        vt[24] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'd4};

        // Reset state
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cnt", 32'(cnt), 0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 25; i++) begin
            req = vt[i].r; len = vt[i].l; hold = vt[i].h;
            tick();
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].g));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].d));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].b));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vt[i].c));
        end

        // Grant order with all requests held and zero lengths
`ifdef TMR_ARB_RR_EN
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        req = '0; hold = 1'b0; len = '0;
        do_reset();
        req = 4'b1111;
        prev_g = '0;
        for (int c = 0; c < 40 && gidx.size() < 5; c++) begin
            tick();
            if (gnt != 0 && prev_g == 0) begin
                gidx.push_back(int'(gnt));
                gcyc.push_back(c);
            end
            prev_g = gnt;
        end
        chk("order_count", 32'(gidx.size()), 5);
        for (int k = 0; k < gidx.size() && k < 5; k++) begin
            chk($sformatf("order_gnt%0d", k), 32'(gidx[k]), 32'(rr_exp[k]));
            if (k > 0) chk($sformatf("order_spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
        end

        // Asynchronous reset in the middle of a run
        req = '0;
        do_reset();
        req = 4'b0001; len = 32'h0000_0014;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (cnt == 8'd7) seen = 1;
        end
        chk("rst_mid_reached7", 32'(seen), 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_cnt", 32'(cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        tick();
        chk("rst_after_gnt", 32'(gnt), 32'(4'b0010));
        chk("rst_after_done", 32'(done), 0);

        // Full-range interval
        req = '0;
        do_reset();
        req = 4'b0001; len = 32'h0000_00FF;
        tick();
        chk("len255_start_cnt", 32'(cnt), 0);
        seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (done != 0) begin
                seen = 1;
                chk("len255_done_cnt", 32'(cnt), 255);
                chk("len255_done", 32'(done), 1);
            end else if (gnt == 0) begin
                chk("len255_early_end", 32'(gnt), 1);
                seen = 1;
            end
        end
        chk("len255_done_seen", 32'(seen), 1);
        req = '0;
        repeat (3) begin
            tick();
            chk("len255_cnt_hold", 32'(cnt), 255);
        end
        req = 4'b0001; len = '0;
        tick();
        chk("len255_regrant_cnt", 32'(cnt), 0);
        chk("len255_regrant_gnt", 32'(gnt), 1);

        // Randomized run against the reference model
        req = '0; hold = 1'b0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NREQ-1:0] r;
            r = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3) r = '0;
            if (m_owner >= 0 && $urandom_range(0, 19) != 0) r[m_owner] = 1'b1;
            req  = r;
            len  = $urandom & 32'h0707_0707;
            hold = ($urandom_range(0, 4) == 0);
            tick();
            chk("rnd_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 0);
            chk("rnd_done", 32'(done), (m_done_to >= 0) ? (32'd1 << m_done_to) : 0);
            chk("rnd_busy", 32'(busy), (m_owner >= 0) ? 1 : 0);
            chk("rnd_cnt", 32'(cnt), 32'(m_cnt_shown[CW-1:0]));
            chk("rnd_onehot", 32'($onehot0(gnt) && $onehot0(done)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
